fft_out_buffer_ctrl: RTL and testbench

FFT_OUT_BUFFER_CTRL -- requirements
Module: fft_out_buffer_ctrl

---
 rtl/fft_out_buffer_ctrl.sv | 143 ++++++++++++++
 tb/tb_fft_out_buffer_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_buffer_ctrl.sv
// Ping-pong output buffer controller for an FFT core.
// One RAM is filled from the core's unload port, addressed by bin index,
// while the other is drained in natural order through a valid/ready port.
// The roles swap only when a frame is complete and the reader is free.
// If the reader is still busy, the completed frame is dropped and the
// sticky overflow flag is raised.

module fft_out_buffer_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       dv_fft_core,
  input  logic [9:0] xk_index,
  input  logic       rd_ready,
  output logic       sel_ram,
  output logic       wr_en_ram_0,
  output logic       wr_en_ram_1,
  output logic [9:0] addr_ram_0,
  output logic [9:0] addr_ram_1,
  output logic       rd_valid,
  output logic       rd_last,
  output logic       overflow
);

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_FETCH   = 2'd1,
    R_PRESENT = 2'd2
  } rd_state_t;

  localparam logic [9:0] LAST_IDX = 10'd1023;

  rd_state_t  state_r;
  rd_state_t  state_nxt_s;
  logic [9:0] wr_cnt_r;
  logic [9:0] rd_cnt_r;
  logic [9:0] rd_cnt_nxt_s;
  logic       sel_ram_r;
  logic       rd_valid_r;
  logic       rd_last_r;
  logic       overflow_r;
  logic       frame_end_s;
  logic       read_free_s;
  logic       swap_s;

  // Frame completion is purely count based; bin indices are never checked.
  assign frame_end_s = dv_fft_core && (wr_cnt_r == LAST_IDX);

  // The reader counts as free if it is idle, or if it is handing off its
  // final sample in this very cycle.
  assign read_free_s = (state_r == R_IDLE) ||
                       ((state_r == R_PRESENT) && rd_last_r && rd_ready);

  assign swap_s = frame_end_s && read_free_s;

  // Read FSM next state and next read address.
  always_comb begin
    state_nxt_s  = state_r;
    rd_cnt_nxt_s = rd_cnt_r;
    case (state_r)
      R_IDLE: begin
        if (swap_s) begin
          state_nxt_s  = R_FETCH;
          rd_cnt_nxt_s = 10'd0;
        end else begin
          state_nxt_s  = R_IDLE;
        end
      end
      R_FETCH: begin
        // One cycle of synchronous RAM read latency.
        state_nxt_s = R_PRESENT;
      end
      R_PRESENT: begin
        if (rd_ready) begin
          if (rd_cnt_r == LAST_IDX) begin
            if (swap_s) begin
              // Back-to-back frame: restart at sample 0 without idling.
              state_nxt_s  = R_FETCH;
              rd_cnt_nxt_s = 10'd0;
            end else begin
              state_nxt_s  = R_IDLE;
            end
          end else begin
            state_nxt_s  = R_FETCH;
            rd_cnt_nxt_s = rd_cnt_r + 10'd1;
          end
        end else begin
          state_nxt_s = R_PRESENT;
        end
      end
      default: begin
        state_nxt_s  = R_IDLE;
        rd_cnt_nxt_s = 10'd0;
      end
    endcase
  end

  // State, counters, buffer select and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= R_IDLE;
      rd_cnt_r   <= 10'd0;
      wr_cnt_r   <= 10'd0;
      sel_ram_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rd_cnt_r   <= rd_cnt_nxt_s;
      rd_valid_r <= (state_nxt_s == R_PRESENT);
      rd_last_r  <= (state_nxt_s == R_PRESENT) && (rd_cnt_nxt_s == LAST_IDX);
      if (dv_fft_core) begin
        wr_cnt_r <= wr_cnt_r + 10'd1;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
      if (swap_s) begin
        sel_ram_r <= ~sel_ram_r;
      end else begin
        sel_ram_r <= sel_ram_r;
      end
      if (frame_end_s && !read_free_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Write enables are gated by reset so nothing is written while held.
  assign wr_en_ram_0 = reset && dv_fft_core && !sel_ram_r;
  assign wr_en_ram_1 = reset && dv_fft_core &&  sel_ram_r;

  // Fill RAM takes the bin index, read RAM takes the read counter.
  assign addr_ram_0 = sel_ram_r ? rd_cnt_r : xk_index;
  assign addr_ram_1 = sel_ram_r ? xk_index : rd_cnt_r;

  assign sel_ram  = sel_ram_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_fft_out_buffer_ctrl.sv
// Scoreboard bench for fft_out_buffer_ctrl with behavioural output RAMs.
// A frame-level model decides at each frame end whether the frame is handed
// to the reader (queue of 1024 expected samples) or dropped (overflow).

module tb_fft_out_buffer_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       dv_fft_core;
  logic [9:0] xk_index;
  logic       rd_ready;
  logic       sel_ram;
  logic       wr_en_ram_0;
  logic       wr_en_ram_1;
  logic [9:0] addr_ram_0;
  logic [9:0] addr_ram_1;
  logic       rd_valid;
  logic       rd_last;
  logic       overflow;

  fft_out_buffer_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .dv_fft_core(dv_fft_core),
    .xk_index   (xk_index),
    .rd_ready   (rd_ready),
    .sel_ram    (sel_ram),
    .wr_en_ram_0(wr_en_ram_0),
    .wr_en_ram_1(wr_en_ram_1),
    .addr_ram_0 (addr_ram_0),
    .addr_ram_1 (addr_ram_1),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
  endtask

  // Behavioural synchronous RAMs driven by the DUT; data comes from the bench.
  logic [15:0] wd;
  logic [15:0] ram0 [1024];
  logic [15:0] ram1 [1024];
  logic [15:0] rdata0, rdata1;

  // RAM write port and registered read port.
  always @(posedge clock) begin
    if (wr_en_ram_0) ram0[addr_ram_0] <= wd;
    if (wr_en_ram_1) ram1[addr_ram_1] <= wd;
    rdata0 <= ram0[addr_ram_0];
    rdata1 <= ram1[addr_ram_1];
  end

  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  assign rd_addr = sel_ram ? addr_ram_0 : addr_ram_1;
  assign rd_data = sel_ram ? rdata0 : rdata1;

  // Reference model state.
  typedef struct {
    logic [9:0]  idx;
    logic [15:0] data;
    logic        last;
    logic        first;
    int          first_cyc;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] mram [2][1024];
  int          wcnt    = 0;
  int          fill    = 0;
  logic        exp_ovf = 1'b0;
  int          cyc     = 0;
  exp_t        e;

  // Frame model: store writes by index, at the 1024th write either hand the
  // whole frame to the reader or drop it when samples are still pending.
  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      wcnt    = 0;
      fill    = 0;
      exp_ovf = 1'b0;
    end else if (dv_fft_core) begin
      mram[fill][xk_index] = wd;
      wcnt++;
      if (wcnt == 1024) begin
        wcnt = 0;
        if (exp_q.size() == 0) begin
          for (int i = 0; i < 1024; i++) begin
            e.idx       = 10'(i);
            e.data      = mram[fill][i];
            e.last      = (i == 1023);
            e.first     = (i == 0);
            e.first_cyc = cyc + 1;
            exp_q.push_back(e);
          end
          fill = 1 - fill;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  logic prev_valid = 1'b0;

  // Monitor: compare outputs against the model away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_sel_ram",  32'(sel_ram),     32'd0);
      chk("rst_rd_valid", 32'(rd_valid),    32'd0);
      chk("rst_rd_last",  32'(rd_last),     32'd0);
      chk("rst_overflow", 32'(overflow),    32'd0);
      chk("rst_wr_en_0",  32'(wr_en_ram_0), 32'd0);
      chk("rst_wr_en_1",  32'(wr_en_ram_1), 32'd0);
      chk("rst_addr_0",   32'(addr_ram_0),  32'(xk_index));
      chk("rst_addr_1",   32'(addr_ram_1),  32'd0);
      prev_valid = 1'b0;
    end else begin
      chk("sel_ram",  32'(sel_ram),     32'(fill));
      chk("overflow", 32'(overflow),    32'(exp_ovf));
      chk("wr_en_0",  32'(wr_en_ram_0), 32'(dv_fft_core && fill == 0));
      chk("wr_en_1",  32'(wr_en_ram_1), 32'(dv_fft_core && fill == 1));
      if (dv_fft_core)
        chk("fill_addr", 32'(fill == 0 ? addr_ram_0 : addr_ram_1), 32'(xk_index));
      if (exp_q.size() == 0) begin
        chk("idle_valid", 32'(rd_valid), 32'd0);
      end else if (rd_valid) begin
        chk("rd_addr", 32'(rd_addr), 32'(exp_q[0].idx));
        chk("rd_data", 32'(rd_data), 32'(exp_q[0].data));
        if (exp_q[0].first && !prev_valid)
          chk("first_latency", 32'(cyc), 32'(exp_q[0].first_cyc));
        if (rd_ready) begin
          chk("rd_last", 32'(rd_last), 32'(exp_q[0].last));
          void'(exp_q.pop_front());
        end
      end
      prev_valid = rd_valid;
    end
  end

  // Stimulus.
  int mode = 0;   // 0 ready, 1 random ready, 2 stalled, 3 stall sample 5
  int hold = 0;

  task automatic step(input logic d, input logic [9:0] x);
    @(posedge clock);
    #1;
    dv_fft_core = d;
    xk_index    = x;
    wd          = 16'($urandom);
    case (mode)
      0: rd_ready = 1'b1;
      1: rd_ready = ($urandom_range(0, 3) != 0);
      2: rd_ready = 1'b0;
      3: begin
        if (rd_valid && rd_addr == 10'd5 && hold < 10) begin
          rd_ready = 1'b0;
          hold++;
        end else begin
          rd_ready = 1'b1;
        end
      end
      default: rd_ready = 1'b1;
    endcase
  endtask

  task automatic write_frame(input int n, input bit rnd, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 10'd0);
      step(1'b1, rnd ? 10'($urandom_range(0, 1023)) : 10'(i));
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 12000; k++) begin
      if (exp_q.size() == 0 && !rd_valid) break;
      step(1'b0, 10'd0);
    end
    chk(name, 32'(exp_q.size() == 0 && !rd_valid), 32'd1);
  endtask

  bit found;

  initial begin
    reset       = 1'b0;
    dv_fft_core = 1'b0;
    xk_index    = 10'd0;
    rd_ready    = 1'b1;
    wd          = 16'd0;
    repeat (3) step(1'b0, 10'd3);
    reset = 1'b1;

    // Basic frame, sequential indices, always ready.
    mode = 0;
    write_frame(1024, 1'b0, 1'b0);
    wait_idle("drain_basic");

    // Backpressure on sample 5.
    mode = 3;
    hold = 0;
    write_frame(1024, 1'b0, 1'b0);
    wait_idle("drain_backpressure");
    chk("bp_hold_cycles", 32'(hold), 32'd10);

    // Random indices with duplicates, gaps and random ready.
    mode = 1;
    write_frame(1024, 1'b1, 1'b1);
    wait_idle("drain_random");

    // Overflow: two more frames complete while the reader is stalled.
    mode = 0;
    write_frame(1024, 1'b0, 1'b0);
    mode = 2;
    write_frame(1024, 1'b1, 1'b0);
    write_frame(1024, 1'b0, 1'b1);
    mode = 0;
    wait_idle("drain_overflow");

    // Simultaneous last-sample accept and frame end.
    write_frame(1024, 1'b1, 1'b0);
    write_frame(1023, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clock);
      #1;
      rd_ready = 1'b1;
      wd       = 16'($urandom);
      if (rd_valid && rd_last) begin
        dv_fft_core = 1'b1;
        xk_index    = 10'd1023;
        found       = 1'b1;
        break;
      end else begin
        dv_fft_core = 1'b0;
      end
    end
    chk("simultaneous_reached", 32'(found), 32'd1);
    wait_idle("drain_simultaneous");

    // Mid-frame reset with dv held high during reset.
    write_frame(500, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) step(1'b1, 10'd7);
    step(1'b0, 10'd0);
    reset = 1'b1;
    mode  = 1;
    write_frame(1023, 1'b1, 1'b1);
    step(1'b0, 10'd0);
    chk("no_swap_before_full", 32'(sel_ram), 32'd0);
    write_frame(1, 1'b0, 1'b0);
    step(1'b0, 10'd0);
    chk("swap_after_full", 32'(sel_ram), 32'd1);
    wait_idle("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
